// File: rtl/reservation_station.sv
// Out-of-order issue queue between the ROB and the ALU: holds dispatched ALU/branch/JALR ops,
// snoops the ALU and memory result buses for operands, and issues the oldest-slot ready op each cycle.
module reservation_station #(
    parameter int         ENTRIES = 4,
    parameter int         TAG_W   = 3,
    parameter logic [4:0] OP_NONE = 5'b11111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       op_in,
    input  logic [31:0]      value1_in,
    input  logic [31:0]      value2_in,
    input  logic [TAG_W-1:0] query1_in,
    input  logic [TAG_W-1:0] query2_in,
    input  logic [31:0]      imm_in,
    input  logic [TAG_W-1:0] target_in,
    input  logic [TAG_W-1:0] alu_num,
    input  logic [31:0]      alu_value,
    input  logic [TAG_W-1:0] mem_num,
    input  logic [31:0]      mem_value,
    output logic             rs_full,
    output logic [4:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [31:0]      alu_imm,
    output logic [TAG_W-1:0] alu_dest,
    output logic             overflow
);

    // Loads and stores (LB..SW) are routed to the load/store unit instead.
    localparam logic [4:0] OP_LB = 5'b10010;
    localparam logic [4:0] OP_SW = 5'b11001;
    localparam int         IDX_W = $clog2(ENTRIES);
    localparam int         CNT_W = $clog2(ENTRIES + 1);

    typedef struct packed {
        logic [TAG_W-1:0] q;
        logic [31:0]      v;
    } opnd_t;

    typedef struct packed {
        logic [4:0]       op;
        opnd_t            o1;
        opnd_t            o2;
        logic [31:0]      imm;
        logic [TAG_W-1:0] dest;
    } slot_t;

    // Operand snoop: the ALU bus has priority over the memory bus; tag 0 never matches.
    function automatic opnd_t snoop(
        input opnd_t            cur,
        input logic [TAG_W-1:0] a_num,
        input logic [31:0]      a_val,
        input logic [TAG_W-1:0] m_num,
        input logic [31:0]      m_val
    );
        opnd_t res;
        res = cur;
        if (cur.q != '0) begin
            if (cur.q == a_num) begin
                res.q = '0;
                res.v = a_val;
            end else if (cur.q == m_num) begin
                res.q = '0;
                res.v = m_val;
            end
        end
        return res;
    endfunction

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    slot_t              slot_q [ENTRIES];
    slot_t              slot_d [ENTRIES];
    slot_t              new_slot;

    logic [ENTRIES-1:0] ready;
    logic               issue_any;
    logic [IDX_W-1:0]   issue_idx;
    logic               free_any;
    logic [IDX_W-1:0]   free_idx;
    logic               accept;
    logic               overflow_d;
    logic [CNT_W-1:0]   cnt_d;

    assign accept = (op_in != OP_NONE) && !((op_in >= OP_LB) && (op_in <= OP_SW));

    // Issue and allocation both look at pre-edge state, so a slot issued this
    // cycle is still marked valid here and cannot be reallocated until next edge.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        ready     = '0;
        issue_any = 1'b0;
        issue_idx = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            ready[i] = valid_q[i] && (slot_q[i].o1.q == '0) && (slot_q[i].o2.q == '0);
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_any = 1'b1;
                issue_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        new_slot.op   = op_in;
        new_slot.o1   = snoop('{q: query1_in, v: value1_in}, alu_num, alu_value, mem_num, mem_value);
        new_slot.o2   = snoop('{q: query2_in, v: value2_in}, alu_num, alu_value, mem_num, mem_value);
        new_slot.imm  = imm_in;
        new_slot.dest = target_in;
    end

    always_comb begin
        valid_d    = valid_q;
        overflow_d = overflow;
        for (int i = 0; i < ENTRIES; i++) begin
            slot_d[i]    = slot_q[i];
            slot_d[i].o1 = snoop(slot_q[i].o1, alu_num, alu_value, mem_num, mem_value);
            slot_d[i].o2 = snoop(slot_q[i].o2, alu_num, alu_value, mem_num, mem_value);
        end
        if (issue_any) begin
            valid_d[issue_idx] = 1'b0;
        end
        if (accept) begin
            if (free_any) begin
                valid_d[free_idx] = 1'b1;
                slot_d[free_idx]  = new_slot;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // Full threshold keeps one slot of slack for the ROB's one-cycle reaction delay.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            cnt_d = cnt_d + CNT_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst) begin
            valid_q  <= '0;
            overflow <= 1'b0;
            rs_full  <= 1'b0;
            alu_op   <= OP_NONE;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_imm  <= '0;
            alu_dest <= '0;
        end else begin
            valid_q  <= valid_d;
            overflow <= overflow_d;
            rs_full  <= (cnt_d >= CNT_W'(ENTRIES - 1));
            if (issue_any) begin
                alu_op   <= slot_q[issue_idx].op;
                alu_a    <= slot_q[issue_idx].o1.v;
                alu_b    <= slot_q[issue_idx].o2.v;
                alu_imm  <= slot_q[issue_idx].imm;
                alu_dest <= slot_q[issue_idx].dest;
            end else begin
                alu_op   <= OP_NONE;
                alu_dest <= '0;
            end
        end
    end

    // NOTE: slot payload is not reset; valid_q gates every use, so only the valid bits need clearing.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            slot_q[i] <= slot_d[i];
        end
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Out-of-order issue queue directly downstream of the reorder buffer (ROB).
- Accepts dispatched ALU, branch and JALR micro-ops carrying ROB tags.
- Tracks operand readiness by snooping the ALU and memory result broadcasts.
- Issues one ready op per cycle to the ALU. Loads and stores bypass this block and go to the load/store unit.

Parameters:
- ENTRIES, 4, number of queue slots (2..8).
- TAG_W, 3, ROB tag width. Tag 0 means "no dependency / no result".
- OP_NONE, 5'b11111, opcode value meaning "no dispatch / no issue".

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- op_in  in  5  dispatched opcode; OP_NONE = idle
- value1_in  in  32  operand 1 value; valid when query1_in==0
- value2_in  in  32  operand 2 value; valid when query2_in==0
- query1_in  in  TAG_W  producer ROB tag for operand 1; 0 = ready
- query2_in  in  TAG_W  producer ROB tag for operand 2; 0 = ready
- imm_in  in  32  immediate, carried unchanged
- target_in  in  TAG_W  destination ROB tag of the dispatched op
- alu_num  in  TAG_W  ALU result broadcast tag; 0 = none
- alu_value  in  32  ALU result broadcast value
- mem_num  in  TAG_W  memory result broadcast tag; 0 = none
- mem_value  in  32  memory result broadcast value
- rs_full  out  1  back-pressure to the ROB
- alu_op  out  5  issued opcode; OP_NONE = no issue
- alu_a  out  32  issued operand 1
- alu_b  out  32  issued operand 2
- alu_imm  out  32  issued immediate
- alu_dest  out  TAG_W  issued ROB tag; 0 when no issue
- overflow  out  1  sticky error flag: a dispatch arrived with no free slot

Behaviour:
- Reset (rst==0 at posedge): all slots invalid, alu_op=OP_NONE, alu_a=alu_b=alu_imm=0, alu_dest=0, rs_full=0, overflow=0. Reset overrides any same-cycle dispatch, wakeup or issue.
- Per-slot state: valid, op, v1, v2, q1, q2, imm, dest. A slot is ready when valid && q1==0 && q2==0.
- Accept rule:
  - Ops 10010..11001 (LB..SW) and OP_NONE are ignored.
  - Any other op_in is written into the lowest-index invalid slot at posedge.
  - If no slot is free, the op is dropped and overflow is set; overflow stays 1 until reset.
- Same-cycle capture at accept: if query1_in is nonzero and equals alu_num (or mem_num), store the broadcast value with q1=0. Same rule for operand 2. If both buses match, alu wins.
- Wakeup: each posedge, every valid slot with qX!=0 and qX==alu_num takes vX=alu_value, qX=0; otherwise a match on mem_num takes vX=mem_value, qX=0. Tag 0 never matches.
- Issue:
  - Selection uses slot state before the edge; choose the lowest-index ready slot.
  - At posedge, register op/v1/v2/imm/dest onto the alu_* outputs and invalidate the slot.
  - With no ready slot: alu_op=OP_NONE, alu_dest=0; alu_a, alu_b and alu_imm hold their previous values.
  - Issue outputs are valid for exactly one cycle.
- Latency:
  - An op dispatched ready at edge N appears on alu_* after edge N+1.
  - An op woken at edge N issues no earlier than edge N+1; there is no same-edge bypass.
- Simultaneous events:
  - Issue and accept in one cycle are both performed.
  - A slot freed at edge N is not reusable until edge N+1.
  - Wakeup and accept both act on the same edge.
- rs_full: registered, computed after the edge as (valid count >= ENTRIES-1). This leaves one slot of slack for the ROB's one-cycle reaction delay.
- Width rules: values are 32-bit and pass through unmodified; no arithmetic is performed in this block.

Test Plan:
- Reset: hold rst=0 for 2 cycles with op_in=ADD -> alu_op=5'b11111, alu_dest=0, rs_full=0, overflow=0. After release, the next ADD (q1=q2=0, v1=5, v2=7, target=3) issues one edge later with alu_op=00000, alu_a=5, alu_b=7, alu_dest=3.
- Dependency wakeup: dispatch SUB with query1=2, v2=10, target=4; two cycles later alu_num=2, alu_value=30 -> SUB issues on the following edge with alu_a=30, alu_b=10, alu_dest=4; no issue before then.
- Same-cycle capture: dispatch BEQ with query2=5 while mem_num=5, mem_value=0x1234 -> issues next edge with alu_b=0x1234; a simultaneous alu_num=5, alu_value=0x9 gives priority to alu (alu_b=9).
- Fill/full (ENTRIES=4): dispatch 3 blocked ops (query1=6) -> rs_full=1 after the third. A 4th op is accepted. A 5th sets overflow=1 and is dropped. Broadcast alu_num=6 -> four ops issue on consecutive edges in slot order, and rs_full drops once the count is <=2.
- Ignored ops: dispatch LW (10100) and SW (11001) -> no slot allocated, no issue, rs_full unchanged.
- Reset mid-operation: with 2 blocked slots, assert rst=0 for one edge while alu_num matches both -> both slots cleared, nothing issues afterwards, overflow=0.
